// File: rtl/ram_pkg.sv
// ram_pkg: shared types and sizing helpers for the LSU data-memory block.
package ram_pkg;
    localparam int RV32_W = 32;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction
    function automatic int cnt_w(input int latency);
        return $clog2(latency + 1);
    endfunction
endpackage

// File: rtl/ram_array.sv
// ram_array: DEPTH x DATA_W storage, byte-strobe synchronous write, combinational read.
import ram_pkg::*;
module ram_array #(
    parameter int DATA_W = RV32_W,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic [strb_w(DATA_W)-1:0] wstrb_i,
    output logic [DATA_W-1:0]       rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < strb_w(DATA_W); b++) begin
                if (wstrb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready front end for ram_array with range check and programmable latency.
import ram_pkg::*;
module ram_ctrl #(
    parameter int DATA_W  = RV32_W,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 1 << ADDR_W,
    parameter int LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);
    localparam int CNT_W = cnt_w(LATENCY);
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] arr_rdata;
    logic              err_q;
    logic              accept;
    logic              in_range;
    assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
    assign accept   = req_valid && (state_q == IDLE);
    ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .we_i    (accept && req_wen && in_range),
        .addr_i  (req_addr),
        .wdata_i (req_wdata),
        .wstrb_i (req_wstrb),
        .rdata_o (arr_rdata)
    );
    // Response is captured at accept; WAIT only burns cycles to model slow memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    rdata_q <= (!req_wen && in_range) ? arr_rdata : '0;
                    err_q   <= !in_range;
                    cnt_q   <= CNT_W'(LATENCY - 2);
                    state_q <= (LATENCY == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q   <= cnt_q - CNT_W'(1);
                    state_q <= (cnt_q == '0) ? RESP : WAIT;
                end
                RESP: if (resp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed checks on a LATENCY=1/DEPTH=256 and a LATENCY=4/DEPTH=200 instance.
module tb_ram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv [2];
    logic        rrdy [2];
    logic        wen [2];
    logic [7:0]  addr [2];
    logic [31:0] wd [2];
    logic [3:0]  ws [2];
    logic        rvld [2];
    logic        rsp_rdy [2];
    logic [31:0] rd [2];
    logic        err [2];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ram_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rrdy[0]), .req_wen(wen[0]),
        .req_addr(addr[0]), .req_wdata(wd[0]), .req_wstrb(ws[0]), .resp_valid(rvld[0]),
        .resp_ready(rsp_rdy[0]), .resp_rdata(rd[0]), .resp_err(err[0]));
    ram_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rrdy[1]), .req_wen(wen[1]),
        .req_addr(addr[1]), .req_wdata(wd[1]), .req_wstrb(ws[1]), .resp_valid(rvld[1]),
        .resp_ready(rsp_rdy[1]), .resp_rdata(rd[1]), .resp_err(err[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request; after accept, a bogus write is kept on the request lines to prove they are ignored.
    task automatic do_req(input int i, input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int hold, input string tag);
        int n;
        rv[i] = 1'b1; wen[i] = w; addr[i] = a; wd[i] = d; ws[i] = s;
        chk({tag, "_ready"}, 32'(rrdy[i]), 32'd1);
        tick();
        wen[i] = 1'b1; wd[i] = ~d; ws[i] = 4'hF;
        n = 1;
        while (rvld[i] !== 1'b1 && n < 10) begin
            chk({tag, "_busy"}, 32'(rrdy[i]), 32'd0);
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_rdata"}, rd[i], exp_rd);
        chk({tag, "_err"}, 32'(err[i]), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            chk({tag, "_hold_rdy"}, 32'(rrdy[i]), 32'd0);
            chk({tag, "_hold_vld"}, 32'(rvld[i]), 32'd1);
            tick();
            chk({tag, "_hold_rd"}, rd[i], exp_rd);
        end
        rsp_rdy[i] = 1'b1;
        tick();
        rsp_rdy[i] = 1'b0; rv[i] = 1'b0; wen[i] = 1'b0;
        chk({tag, "_done_vld"}, 32'(rvld[i]), 32'd0);
    endtask

    initial begin
        logic [7:0]  b2b_a [4];
        logic [31:0] b2b_e [3];
        for (int i = 0; i < 2; i++) begin
            rv[i] = 0; wen[i] = 0; addr[i] = 0; wd[i] = 0; ws[i] = 0; rsp_rdy[i] = 0;
        end
        #12 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(rrdy[i]), 32'd1);
            chk("rst_valid", 32'(rvld[i]), 32'd0);
            chk("rst_rdata", rd[i], 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
        end
        do_req(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1, 0, "t1_wr");
        do_req(0, 1, 8'h30, 32'h0BADCAFE, 4'hF, 32'h0, 0, 1, 0, "t1_wr30");
        do_req(0, 0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, 0, "t1_rd");
        do_req(0, 1, 8'h20, 32'h11223344, 4'hF, 32'h0, 0, 1, 0, "t2_wr_full");
        do_req(0, 1, 8'h20, 32'hAABBCCDD, 4'h5, 32'h0, 0, 1, 0, "t2_wr_strb");
        do_req(0, 0, 8'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 1, 0, "t2_rd");
        do_req(0, 1, 8'h10, 32'h0, 4'h0, 32'h0, 0, 1, 0, "strb0_wr");
        do_req(0, 0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, 0, "strb0_rd");
        do_req(1, 1, 8'd5, 32'h12345678, 4'hF, 32'h0, 0, 4, 0, "t3_wr");
        do_req(1, 0, 8'd5, 32'h0, 4'h0, 32'h12345678, 0, 4, 3, "t3_rd");
        do_req(1, 1, 8'd199, 32'hCAFEF00D, 4'hF, 32'h0, 0, 4, 0, "t4_wr199");
        do_req(1, 1, 8'd200, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 4, 0, "t4_wr200");
        do_req(1, 0, 8'd199, 32'h0, 4'h0, 32'hCAFEF00D, 0, 4, 0, "t4_rd199");
        do_req(1, 0, 8'd200, 32'h0, 4'h0, 32'h0, 1, 4, 0, "t4_rd200");
        do_req(1, 0, 8'd255, 32'h0, 4'h0, 32'h0, 1, 4, 0, "t4_rd255");
        rv[1] = 1'b1; wen[1] = 1'b1; addr[1] = 8'd7; wd[1] = 32'h5A5A1234; ws[1] = 4'hF;
        tick();
        rv[1] = 1'b0; wen[1] = 1'b0;
        tick();
        chk("t5_in_wait", 32'(rrdy[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(rrdy[1]), 32'd1);
        chk("t5_rst_valid", 32'(rvld[1]), 32'd0);
        #2 rst_n = 1'b1;
        repeat (4) tick();
        chk("t5_no_resp", 32'(rvld[1]), 32'd0);
        do_req(1, 0, 8'd7, 32'h0, 4'h0, 32'h5A5A1234, 0, 4, 0, "t5_rd");
        b2b_a[0] = 8'h10; b2b_a[1] = 8'h20; b2b_a[2] = 8'h30; b2b_a[3] = 8'h00;
        b2b_e[0] = 32'hDEADBEEF; b2b_e[1] = 32'h11BB33DD; b2b_e[2] = 32'h0BADCAFE;
        rsp_rdy[0] = 1'b1; rv[0] = 1'b1; wen[0] = 1'b0; addr[0] = b2b_a[0];
        for (int k = 0; k < 3; k++) begin
            chk("t6_ready", 32'(rrdy[0]), 32'd1);
            tick();
            chk("t6_valid", 32'(rvld[0]), 32'd1);
            chk("t6_rdata", rd[0], b2b_e[k]);
            addr[0] = b2b_a[k+1];
            if (k == 2) rv[0] = 1'b0;
            tick();
        end
        chk("t6_idle_ready", 32'(rrdy[0]), 32'd1);
        tick();
        chk("t6_no_extra", 32'(rvld[0]), 32'd0);
        rsp_rdy[0] = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
